// File: rtl/encode_pkg.sv
// encode_pkg: shared state type and counter sizing helper for the encode blocks.
package encode_pkg;

    typedef enum logic {IDLE, SHIFT} t_ser_state;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick.sv
// tick: free-running modulo-p_div counter with synchronous clear and a terminal-count strobe.
module tick
    import encode_pkg::*;
#(
    parameter int p_div = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic stb_o
);

    localparam int CW = cnt_w(p_div);
    localparam logic [CW-1:0] TC = CW'(p_div - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign stb_o = cnt_q == TC;
    assign cnt_d = (clr_i || stb_o) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/serial.sv
// serial: parallel-to-serial converter, MSB first, one step strobe per bit every p_div clocks.
// Back-to-back words are reloaded in the o_end cycle so the strobe cadence never breaks.
module serial
    import encode_pkg::*;
#(
    parameter int p_width = 8,
    parameter int p_div   = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [p_width-1:0] i_val,
    input  logic               i_req,
    output logic               o_rdy,
    output logic               o_val,
    output logic               o_stp,
    output logic               o_end
);

    localparam int BW = cnt_w(p_width);

    t_ser_state         state_q, state_d;
    logic [p_width-1:0] shreg_q, shreg_d, word;
    logic [BW-1:0]      bcnt_q, bcnt_d;
    logic               val_q, val_d, stp_q, end_q, end_d;
    logic               acc, done, strb, tk, last, clr;

    assign o_rdy = (state_q == IDLE) || end_q;
    assign o_val = val_q;
    assign o_stp = stp_q;
    assign o_end = end_q;

    // The divider keeps running across a reload so the next bit lands exactly p_div later.
    tick #(.p_div(p_div)) u_tick (
        .clk_i (i_clk),
        .rst_ni(i_rst),
        .clr_i (clr),
        .stb_o (strb)
    );

    always_comb begin
        acc     = i_req && o_rdy;
        done    = end_q && !acc;
        clr     = (state_q == IDLE) || done;
        tk      = (state_q == SHIFT) && strb && !done;
        last    = bcnt_q == BW'(p_width - 1);
        word    = acc ? i_val : shreg_q;
        shreg_d = tk ? word << 1 : done ? '0 : word;
        bcnt_d  = (done || (tk && last)) ? '0 : tk ? bcnt_q + 1'b1 : bcnt_q;
        state_d = acc ? SHIFT : done ? IDLE : state_q;
        end_d   = tk && last;
        val_d   = (state_d == SHIFT) && word[p_width-1];
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bcnt_q  <= '0;
            val_q   <= 1'b0;
            stp_q   <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
            val_q   <= val_d;
            stp_q   <= tk;
            end_q   <= end_d;
        end
    end

endmodule

// File: tb/tb_serial.sv
// tb_serial: directed checks of the serialiser timing plus a randomized run against a word-level model.
module tb_serial;

    localparam int W = 8;
    localparam int DV[2] = '{4, 1};

    logic       clk, rst_n, req;
    logic [W-1:0] val_in;
    logic [1:0] rdy, val, stp, endo;
    int checks, failures;
    bit [2:0] ex [2][0:2047];

    serial #(.p_width(W), .p_div(4)) dut0 (
        .i_clk(clk), .i_rst(rst_n), .i_val(val_in), .i_req(req),
        .o_rdy(rdy[0]), .o_val(val[0]), .o_stp(stp[0]), .o_end(endo[0])
    );

    serial #(.p_width(W), .p_div(1)) dut1 (
        .i_clk(clk), .i_rst(rst_n), .i_val(val_in), .i_req(req),
        .o_rdy(rdy[1]), .o_val(val[1]), .o_stp(stp[1]), .o_end(endo[1])
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({rdy[d], val[d], stp[d], endo[d]} !== 4'b1000) begin
                failures++;
                $display("FAIL reset_hold dut%0d got=%b exp=1000", d, {rdy[d], val[d], stp[d], endo[d]});
            end
        end
        repeat (3) step();
        rst_n = 1;
        for (int k = 0; k < 20; k++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({rdy[d], val[d], stp[d], endo[d]} !== 4'b1000) begin
                    failures++;
                    $display("FAIL reset_idle dut%0d k=%0d got=%b exp=1000", d, k, {rdy[d], val[d], stp[d], endo[d]});
                end
            end
        end
    endtask

    task automatic test_single();
        logic [W-1:0] bits;
        int n;
        bits = '0;
        n = 0;
        val_in = 8'hA5;
        req = 1;
        step();
        req = 0;
        for (int k = 1; k <= 40; k++) begin
            val_in = W'($urandom);
            step();
            checks++;
            if (stp[0] !== (k % 4 == 0 && k <= 32)) begin
                failures++;
                $display("FAIL single_stp k=%0d got=%b exp=%b", k, stp[0], (k % 4 == 0 && k <= 32));
            end
            checks++;
            if (endo[0] !== (k == 32)) begin
                failures++;
                $display("FAIL single_end k=%0d got=%b exp=%b", k, endo[0], (k == 32));
            end
            checks++;
            if (rdy[0] !== (k >= 32)) begin
                failures++;
                $display("FAIL single_rdy k=%0d got=%b exp=%b", k, rdy[0], (k >= 32));
            end
            if (stp[0]) begin
                bits = {bits[W-2:0], val[0]};
                n++;
            end
        end
        checks++;
        if (bits !== 8'hA5 || n != 8) begin
            failures++;
            $display("FAIL single_bits got=%h/%0d exp=a5/8", bits, n);
        end
        val_in = '0;
        repeat (20) step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits;
        int n;
        bits = '0;
        n = 0;
        val_in = 8'hFF;
        req = 1;
        step();
        val_in = 8'h00;
        for (int k = 1; k <= 70; k++) begin
            step();
            if (k == 33) req = 0;
            checks++;
            if (stp[0] !== (k % 4 == 0 && k <= 64)) begin
                failures++;
                $display("FAIL b2b_stp k=%0d got=%b exp=%b", k, stp[0], (k % 4 == 0 && k <= 64));
            end
            checks++;
            if (endo[0] !== (k == 32 || k == 64)) begin
                failures++;
                $display("FAIL b2b_end k=%0d got=%b exp=%b", k, endo[0], (k == 32 || k == 64));
            end
            checks++;
            if (rdy[0] !== (k == 32 || k >= 64)) begin
                failures++;
                $display("FAIL b2b_rdy k=%0d got=%b exp=%b", k, rdy[0], (k == 32 || k >= 64));
            end
            if (stp[0]) begin
                bits = {bits[14:0], val[0]};
                n++;
            end
        end
        checks++;
        if (bits !== 16'hFF00 || n != 16) begin
            failures++;
            $display("FAIL b2b_bits got=%h/%0d exp=ff00/16", bits, n);
        end
        repeat (40) step();
    endtask

    task automatic test_busy();
        logic [W-1:0] bits;
        int n;
        bits = '0;
        n = 0;
        val_in = 8'h3C;
        req = 1;
        step();
        req = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 9) begin
                req = 1;
                val_in = 8'hFF;
            end
            if (k == 10) req = 0;
            checks++;
            if (stp[0] !== (k % 4 == 0 && k <= 32) || endo[0] !== (k == 32)) begin
                failures++;
                $display("FAIL busy_timing k=%0d got=%b%b exp=%b%b", k, stp[0], endo[0], (k % 4 == 0 && k <= 32), (k == 32));
            end
            if (stp[0]) begin
                bits = {bits[W-2:0], val[0]};
                n++;
            end
        end
        checks++;
        if (bits !== 8'h3C || n != 8) begin
            failures++;
            $display("FAIL busy_bits got=%h/%0d exp=3c/8", bits, n);
        end
        repeat (40) step();
    endtask

    task automatic test_div1();
        logic [W-1:0] bits;
        bits = '0;
        val_in = 8'h81;
        req = 1;
        step();
        req = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (stp[1] !== (k <= 8) || endo[1] !== (k == 8)) begin
                failures++;
                $display("FAIL div1_timing k=%0d got=%b%b exp=%b%b", k, stp[1], endo[1], (k <= 8), (k == 8));
            end
            if (stp[1]) bits = {bits[W-2:0], val[1]};
        end
        checks++;
        if (bits !== 8'h81) begin
            failures++;
            $display("FAIL div1_bits got=%h exp=81", bits);
        end
        repeat (40) step();
    endtask

    task automatic test_reset_mid();
        val_in = 8'hA5;
        req = 1;
        step();
        req = 0;
        repeat (13) step();
        #3;
        rst_n = 0;
        #1;
        checks++;
        if ({rdy[0], val[0], stp[0], endo[0]} !== 4'b1000) begin
            failures++;
            $display("FAIL midreset_async got=%b exp=1000", {rdy[0], val[0], stp[0], endo[0]});
        end
        step();
        step();
        rst_n = 1;
        for (int k = 0; k < 40; k++) begin
            step();
            checks++;
            if ({rdy[0], val[0], stp[0], endo[0]} !== 4'b1000) begin
                failures++;
                $display("FAIL midreset_after k=%0d got=%b exp=1000", k, {rdy[0], val[0], stp[0], endo[0]});
            end
        end
    endtask

    // Model: a word accepted from idle gets its first bit p_div cycles after the accept edge;
    // a word accepted in the o_end cycle continues the previous word's bit cadence.
    task automatic test_random();
        int endc[2];
        int cyc, first;
        rst_n = 0;
        req = 0;
        step();
        rst_n = 1;
        endc = '{-1, -1};
        cyc = 0;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2048; c++) ex[d][c] = 3'b000;
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 0;
                req = 0;
                #1;
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if ({rdy[d], val[d], stp[d], endo[d]} !== 4'b1000) begin
                        failures++;
                        $display("FAIL rand_reset dut%0d cyc=%0d got=%b exp=1000", d, cyc, {rdy[d], val[d], stp[d], endo[d]});
                    end
                    endc[d] = -1;
                    for (int c = cyc; c < 2048; c++) ex[d][c] = 3'b000;
                end
                step();
                cyc++;
                rst_n = 1;
            end
            req = (i % 300 < 200) ? ($urandom_range(0, 3) == 0) : 1'b1;
            val_in = W'($urandom);
            for (int d = 0; d < 2; d++) begin
                if (req && cyc >= endc[d]) begin
                    first = (cyc == endc[d]) ? cyc + DV[d] : cyc + 1 + DV[d];
                    for (int k = 0; k < W; k++)
                        ex[d][first + k * DV[d]] = {1'b1, k == W - 1, val_in[W-1-k]};
                    endc[d] = first + (W - 1) * DV[d];
                end
            end
            step();
            cyc++;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (stp[d] !== ex[d][cyc][2] || endo[d] !== ex[d][cyc][1]) begin
                    failures++;
                    $display("FAIL rand_strobe dut%0d cyc=%0d got=%b%b exp=%b%b", d, cyc, stp[d], endo[d], ex[d][cyc][2], ex[d][cyc][1]);
                end
                checks++;
                if (rdy[d] !== (cyc >= endc[d])) begin
                    failures++;
                    $display("FAIL rand_rdy dut%0d cyc=%0d got=%b exp=%b", d, cyc, rdy[d], (cyc >= endc[d]));
                end
                if (ex[d][cyc][2]) begin
                    checks++;
                    if (val[d] !== ex[d][cyc][0]) begin
                        failures++;
                        $display("FAIL rand_bit dut%0d cyc=%0d got=%b exp=%b", d, cyc, val[d], ex[d][cyc][0]);
                    end
                end
                if (cyc > endc[d]) begin
                    checks++;
                    if (val[d] !== 1'b0) begin
                        failures++;
                        $display("FAIL rand_idle_val dut%0d cyc=%0d got=%b exp=0", d, cyc, val[d]);
                    end
                end
            end
        end
        req = 0;
    endtask

    initial begin
        clk = 0;
        rst_n = 0;
        req = 0;
        val_in = '0;
        checks = 0;
        failures = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_busy();
        test_div1();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
